// File: rtl/day1_pkg.sv
// Shared definitions for the day-1 dial puzzle blocks.
//   ASCII byte constants used by the instruction parser,
//   parser FSM state type,
//   dial direction encoding shared with day1_solution_top.
package day1_pkg;

    localparam logic [7:0] CH_L  = 8'h4C;  // 'L'
    localparam logic [7:0] CH_R  = 8'h52;  // 'R'
    localparam logic [7:0] CH_0  = 8'h30;  // '0'
    localparam logic [7:0] CH_9  = 8'h39;  // '9'
    localparam logic [7:0] CH_LF = 8'h0A;  // '\n'
    localparam logic [7:0] CH_CR = 8'h0D;  // '\r'
    localparam logic [7:0] CH_SP = 8'h20;  // ' '

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StDigits,
        StEmit,
        StSkip,
        StDone
    } parser_state_e;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_0) && (c <= CH_9);
    endfunction

endpackage

// File: rtl/day1_decimal_accumulator.sv
// Decimal accumulator for the instruction parser.
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   clear       in   zero the value and forget any digits seen
//   step        in   fold digit in: value = value*10 + digit (ignored on overflow)
//   digit       in   BCD digit 0..9
//   value       out  current accumulated value
//   has_digits  out  at least one digit has been folded in since clear
//   overflow    out  folding digit in now would exceed 2^COUNT_WIDTH-1
module day1_decimal_accumulator #(
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   step,
    input  logic [3:0]             digit,
    output logic [COUNT_WIDTH-1:0] value,
    output logic                   has_digits,
    output logic                   overflow
);

    logic [COUNT_WIDTH-1:0] value_q;
    logic                   has_digits_q;
    // Four spare bits: value*10 + 9 < 16 * 2^COUNT_WIDTH.
    logic [COUNT_WIDTH+3:0] wide;

    always_comb begin
        wide = ({4'b0000, value_q} << 3) + ({4'b0000, value_q} << 1)
             + {{COUNT_WIDTH{1'b0}}, digit};
        overflow = |wide[COUNT_WIDTH+3:COUNT_WIDTH];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value_q      <= '0;
            has_digits_q <= 1'b0;
        end else if (clear) begin
            value_q      <= '0;
            has_digits_q <= 1'b0;
        end else if (step && !overflow) begin
            value_q      <= wide[COUNT_WIDTH-1:0];
            has_digits_q <= 1'b1;
        end
    end

    assign value      = value_q;
    assign has_digits = has_digits_q;

endmodule

// File: rtl/day1_instruction_parser.sv
// Turns the raw day-1 puzzle byte stream ("L68\nR48\n...") into {direction, count}
// instructions offered on a valid/ready handshake.
//   clock, reset                 clock and asynchronous active-low reset
//   in_data/in_valid/in_last     byte stream input; in_last marks end of file
//   in_ready                     byte accepted when in_valid & in_ready
//   direction/count              instruction payload (1 = 'R'), stable while valid
//   instruction_valid/_ready     instruction handshake
//   instructions_sent            accepted instructions since reset (saturating)
//   parse_errors                 dropped malformed lines since reset (saturating)
//   done                         end of file consumed and last instruction accepted
module day1_instruction_parser
    import day1_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 16,
    parameter int unsigned STAT_WIDTH  = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic                   direction,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   instruction_valid,
    input  logic                   instruction_ready,
    output logic [STAT_WIDTH-1:0]  instructions_sent,
    output logic [STAT_WIDTH-1:0]  parse_errors,
    output logic                   done
);

    parser_state_e          state_q;
    logic                   in_ready_q;
    logic                   valid_q;
    logic                   direction_q;
    logic                   last_seen_q;
    logic                   done_q;
    logic [STAT_WIDTH-1:0]  sent_q;
    logic [STAT_WIDTH-1:0]  errors_q;

    logic                   accept;
    logic                   is_num;
    logic                   is_lf;
    logic                   is_cr;
    logic                   is_ws;
    logic                   is_letter;
    logic                   line_end;
    logic                   acc_clear;
    logic                   acc_step;
    logic                   acc_has_digits;
    logic                   acc_overflow;
    logic [COUNT_WIDTH-1:0] acc_value;

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(STAT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        accept    = in_valid & in_ready_q;
        is_num    = is_digit(in_data);
        is_lf     = (in_data == CH_LF);
        is_cr     = (in_data == CH_CR);
        is_ws     = is_lf | is_cr | (in_data == CH_SP);
        is_letter = (in_data == CH_L) | (in_data == CH_R);
        // A CR only terminates a line when it is the final byte of the file.
        line_end  = is_lf | (is_cr & in_last);
        acc_clear = accept & (state_q == StIdle) & is_letter;
        acc_step  = accept & (state_q == StDigits) & is_num;
    end

    day1_decimal_accumulator #(
        .COUNT_WIDTH(COUNT_WIDTH)
    ) u_acc (
        .clock      (clock),
        .reset      (reset),
        .clear      (acc_clear),
        .step       (acc_step),
        .digit      (in_data[3:0]),
        .value      (acc_value),
        .has_digits (acc_has_digits),
        .overflow   (acc_overflow)
    );

    // in_ready_q defaults high each cycle; branches entering or holding EMIT/DONE pull it low.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b0;
            valid_q     <= 1'b0;
            direction_q <= DIR_LEFT;
            last_seen_q <= 1'b0;
            done_q      <= 1'b0;
            sent_q      <= '0;
            errors_q    <= '0;
        end else begin
            in_ready_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (in_last) begin
                            // A lone letter at end of file is an incomplete line.
                            if (!is_ws) errors_q <= sat_inc(errors_q);
                            state_q    <= StDone;
                            in_ready_q <= 1'b0;
                            done_q     <= 1'b1;
                        end else if (is_letter) begin
                            direction_q <= (in_data == CH_R) ? DIR_RIGHT : DIR_LEFT;
                            state_q     <= StDigits;
                        end else if (!is_ws) begin
                            errors_q <= sat_inc(errors_q);
                            state_q  <= StSkip;
                        end
                    end
                end
                StDigits: begin
                    if (accept) begin
                        if (is_num && !acc_overflow) begin
                            if (in_last) begin
                                state_q     <= StEmit;
                                valid_q     <= 1'b1;
                                last_seen_q <= 1'b1;
                                in_ready_q  <= 1'b0;
                            end
                        end else if (line_end && acc_has_digits) begin
                            state_q     <= StEmit;
                            valid_q     <= 1'b1;
                            last_seen_q <= in_last;
                            in_ready_q  <= 1'b0;
                        end else if (is_num || line_end || !is_cr) begin
                            // Overflow, empty line, or a stray byte: drop the line.
                            errors_q <= sat_inc(errors_q);
                            if (in_last) begin
                                state_q    <= StDone;
                                in_ready_q <= 1'b0;
                                done_q     <= 1'b1;
                            end else begin
                                state_q <= is_lf ? StIdle : StSkip;
                            end
                        end
                    end
                end
                StSkip: begin
                    if (accept) begin
                        if (in_last) begin
                            state_q    <= StDone;
                            in_ready_q <= 1'b0;
                            done_q     <= 1'b1;
                        end else if (is_lf) begin
                            state_q <= StIdle;
                        end
                    end
                end
                StEmit: begin
                    if (instruction_ready) begin
                        valid_q <= 1'b0;
                        sent_q  <= sat_inc(sent_q);
                        if (last_seen_q) begin
                            state_q    <= StDone;
                            in_ready_q <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        in_ready_q <= 1'b0;
                    end
                end
                StDone: begin
                    in_ready_q <= 1'b0;
                    done_q     <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready          = in_ready_q;
    assign direction         = direction_q;
    assign count             = acc_value;
    assign instruction_valid = valid_q;
    assign instructions_sent = sent_q;
    assign parse_errors      = errors_q;
    assign done              = done_q;

endmodule

// File: tb/tb_day1_instruction_parser.sv
// Randomised and directed bench for day1_instruction_parser. Expected instructions and
// error counts come from a line-oriented text model of the puzzle format.
module tb_day1_instruction_parser;

    logic        clock;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic        direction;
    logic [15:0] count;
    logic        instruction_valid;
    logic        instruction_ready;
    logic [31:0] instructions_sent;
    logic [31:0] parse_errors;
    logic        done;

    day1_instruction_parser dut (
        .clock             (clock),
        .reset             (rst_n),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_last           (in_last),
        .in_ready          (in_ready),
        .direction         (direction),
        .count             (count),
        .instruction_valid (instruction_valid),
        .instruction_ready (instruction_ready),
        .instructions_sent (instructions_sent),
        .parse_errors      (parse_errors),
        .done              (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [7:0]  stim_q[$];
    logic [7:0]  line_q[$];
    logic [16:0] exp_q[$];
    logic [16:0] got_q[$];
    int          exp_errs;
    int          first_acc;
    int          rdy_after_first;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_str(input string s);
        stim_q.delete();
        for (int i = 0; i < s.len(); i++) stim_q.push_back(s[i]);
    endtask

    // One text line: optional leading CR/space, a letter, then digits (CR ignored).
    task automatic model_line();
        int     i;
        logic   dir;
        longint val;
        int     nd;
        bit     bad;
        i = 0;
        while (i < line_q.size() && (line_q[i] == 8'h0D || line_q[i] == 8'h20)) i++;
        if (i == line_q.size()) return;
        if (line_q[i] != "L" && line_q[i] != "R") begin
            exp_errs++;
            return;
        end
        dir = (line_q[i] == "R");
        val = 0;
        nd  = 0;
        bad = 0;
        for (int j = i + 1; j < line_q.size(); j++) begin
            if (line_q[j] == 8'h0D) continue;
            if (line_q[j] >= "0" && line_q[j] <= "9" && !bad) begin
                val = val * 10 + longint'(line_q[j] - 8'h30);
                nd++;
                if (val > 65535) bad = 1;
            end else begin
                bad = 1;
            end
        end
        if (bad || nd == 0) exp_errs++;
        else exp_q.push_back({dir, val[15:0]});
    endtask

    task automatic model_file();
        exp_q.delete();
        exp_errs = 0;
        line_q.delete();
        foreach (stim_q[i]) begin
            if (stim_q[i] == 8'h0A) begin
                model_line();
                line_q.delete();
            end else begin
                line_q.push_back(stim_q[i]);
            end
        end
        model_line();
    endtask

    task automatic gen_file();
        int    n;
        string s;
        string num;
        stim_q.delete();
        n = $urandom_range(1, 6);
        for (int l = 0; l < n; l++) begin
            case ($urandom_range(0, 9))
                6:       s = $sformatf("X%0d", $urandom_range(0, 99));
                7:       s = ($urandom % 2) ? "" : "  ";
                8:       s = "R";
                9:       s = "L1 2";
                default: begin
                    case ($urandom_range(0, 3))
                        0:       num = $sformatf("%0d", $urandom_range(0, 9));
                        1:       num = $sformatf("%0d", $urandom_range(0, 999));
                        2:       num = $sformatf("%0d", $urandom_range(0, 65535));
                        default: num = $sformatf("%0d", $urandom_range(65530, 65545));
                    endcase
                    if ($urandom % 5 == 0) num = {"0", num};
                    s = {(($urandom % 2) ? "R" : "L"), num};
                end
            endcase
            if ($urandom % 4 == 0) s = {s, "\015"};
            if (l < n - 1 || ($urandom % 2)) s = {s, "\n"};
            for (int i = 0; i < s.len(); i++) stim_q.push_back(s[i]);
        end
        if (stim_q.size() == 0) stim_q.push_back(8'h0A);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        rst_n             = 1'b0;
        in_valid          = 1'b0;
        in_last           = 1'b0;
        in_data           = 8'h00;
        instruction_ready = 1'b0;
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
    endtask

    // mode 0: ready tied high, back-to-back bytes; 1: random gaps and ready;
    // 2: ready held low for the first 10 valid cycles of each instruction.
    task automatic run_file(input int mode, input int max_cyc);
        int          idx;
        int          cyc;
        int          vcyc;
        bit          pend;
        bit          just_acc;
        bit          fin;
        logic [16:0] held;
        idx = 0; cyc = 0; vcyc = 0; pend = 0; just_acc = 0; fin = 0;
        held = '0;
        got_q.delete();
        first_acc       = 0;
        rdy_after_first = -1;
        while (!fin && cyc < max_cyc) begin
            @(negedge clock);
            cyc++;
            if (just_acc && rdy_after_first < 0) rdy_after_first = int'(in_ready);
            just_acc = 0;
            if (instruction_valid) begin
                vcyc++;
                check_eq("in_ready_low_in_emit", in_ready, 0);
                if (pend) check_eq("payload_stable", {direction, count}, held);
                case (mode)
                    0:       instruction_ready = 1'b1;
                    1:       instruction_ready = $urandom_range(0, 1);
                    default: instruction_ready = (vcyc > 10);
                endcase
                if (instruction_ready) begin
                    got_q.push_back({direction, count});
                    if (first_acc == 0) begin
                        first_acc = vcyc;
                        just_acc  = 1;
                    end
                    pend = 0;
                    vcyc = 0;
                end else begin
                    pend = 1;
                    held = {direction, count};
                end
            end else begin
                if (pend) check_eq("valid_held", instruction_valid, 1);
                pend              = 0;
                instruction_ready = $urandom_range(0, 1);
            end
            if (idx < stim_q.size()) begin
                in_valid = (mode == 1) ? ($urandom % 4 != 0) : 1'b1;
                in_data  = stim_q[idx];
                in_last  = (idx == stim_q.size() - 1);
                if (in_valid && in_ready) idx++;
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                in_data  = 8'h00;
            end
            if (done && idx == stim_q.size() && !instruction_valid) fin = 1;
        end
        @(negedge clock);
        in_valid          = 1'b0;
        in_last           = 1'b0;
        instruction_ready = 1'b0;
    endtask

    task automatic compare_file(input string name);
        int n;
        check_eq({name, "_n_instr"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check_eq($sformatf("%s_instr%0d", name, i), got_q[i], exp_q[i]);
        check_eq({name, "_sent"}, instructions_sent, exp_q.size());
        check_eq({name, "_errors"}, parse_errors, exp_errs);
        check_eq({name, "_done"}, done, 1);
        check_eq({name, "_in_ready_done"}, in_ready, 0);
    endtask

    task automatic directed(input string name, input string s, input int mode);
        apply_reset();
        load_str(s);
        model_file();
        run_file(mode, 2000);
        compare_file(name);
    endtask

    initial begin
        int idx;
        rst_n             = 1'b0;
        in_valid          = 1'b0;
        in_last           = 1'b0;
        in_data           = 8'h00;
        instruction_ready = 1'b0;
        #22;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_valid", instruction_valid, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_sent", instructions_sent, 0);
        check_eq("rst_errors", parse_errors, 0);
        check_eq("rst_count", count, 0);
        check_eq("rst_direction", direction, 0);
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        check_eq("rel_in_ready", in_ready, 1);

        directed("two_lines", "L68\nR48\n", 0);
        directed("hold", "R5\nL2\n", 2);
        check_eq("hold_accept_cycle", first_acc, 11);
        check_eq("hold_in_ready_back", rdy_after_first, 1);
        directed("bad_letter", "X12\nL3\n", 0);
        directed("overflow", "R65536\nL65535\n", 0);
        directed("crlf_last", "L1\015\nR2", 1);
        directed("lone_letter", "R0\nL", 1);

        // Reset while an instruction is pending.
        apply_reset();
        load_str("R9\n");
        idx = 0;
        for (int c = 0; c < 50 && !instruction_valid; c++) begin
            @(negedge clock);
            instruction_ready = 1'b0;
            if (idx < stim_q.size() && !instruction_valid) begin
                in_valid = 1'b1;
                in_data  = stim_q[idx];
                in_last  = 1'b0;
                if (in_ready) idx++;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check_eq("emit_before_reset", instruction_valid, 1);
        #3 rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", instruction_valid, 0);
        check_eq("midrst_in_ready", in_ready, 0);
        check_eq("midrst_sent", instructions_sent, 0);
        check_eq("midrst_errors", parse_errors, 0);
        @(negedge clock);
        rst_n = 1'b1;
        load_str("R7\n");
        model_file();
        run_file(0, 2000);
        compare_file("after_rst");

        for (int t = 0; t < 40; t++) begin
            apply_reset();
            gen_file();
            model_file();
            run_file(1, 3000);
            compare_file($sformatf("rand%0d", t));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
